// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the MIPS core data bus. It is a word-addressed RAM
// behind a memreq/memready handshake with a programmable number of wait
// states. It also has a mailbox: a write to MAILBOX_ADDR sets the sticky
// 'done' flag and captures 'result', so a test program can report pass/fail.
//
// Transaction flow: IDLE -> (WAIT x WAIT_CYCLES) -> RESP -> IDLE.
// A request sampled at edge N raises memready in cycle N+1+WAIT_CYCLES for
// exactly one cycle. Back-to-back accesses complete once every
// WAIT_CYCLES+2 cycles.
//
// Parameters
//   ADDR_W        word-index bits; RAM depth is 2**ADDR_W 32-bit words
//   WAIT_CYCLES   wait states before memready (0..15)
//   MAILBOX_ADDR  byte address whose writes update done/result
//   INIT_FILE     name of an optional hex image
//
// Ports
//   clk        in   1   single clock, all state on posedge
//   reset      in   1   synchronous, active-high
//   memreq     in   1   request valid, held by the core until memready
//   memwrite   in   1   1 = write, 0 = read, sampled with memreq
//   dataadr    in   32  byte address
//   writedata  in   32  write data
//   readdata   out  32  read data, valid while memready=1 on a read
//   memready   out  1   one-cycle completion pulse
//   done       out  1   sticky: mailbox written since reset
//   result     out  32  last value written to the mailbox
//   misalign   out  1   misaligned-access flag (RESP cycle only)
//
// Configuration macro: ALIGN_CHECK_EN
//   defined   : an access with dataadr[1:0] != 0 updates neither RAM nor the
//               mailbox, a read returns 32'hDEADBEEF, and misalign pulses
//               with memready.
//   undefined : dataadr[1:0] is ignored, so the access goes to the enclosing
//               word, and misalign is tied to 0.
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int          ADDR_W       = 6,
    parameter int          WAIT_CYCLES  = 2,
    parameter logic [31:0] MAILBOX_ADDR = 32'h54,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        memready,
    output logic        done,
    output logic [31:0] result,
    output logic        misalign
);

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [31:0] BAD_READ = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Control state (reset)
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        misal_q, misal_d;

    // Latched request (data path, not reset)
    logic [29:0] wadr_q, wadr_d;     // word address, dataadr[31:2]
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;

    logic [31:0] ram [DEPTH];

    logic        req_misal;
    logic        mbox_hit;
    logic        ram_we;

`ifdef ALIGN_CHECK_EN
    assign req_misal = (dataadr[1:0] != 2'b00);
    assign misalign  = (state_q == ST_RESP) && misal_q;
`else
    // The byte offset plays no part without the alignment check.
    logic unused_byte_offset;
    assign unused_byte_offset = ^dataadr[1:0];
    assign req_misal = 1'b0;
    assign misalign  = 1'b0;
`endif

    // The mailbox compare covers the whole word address, so an aliased
    // address that only shares the RAM index does not count as a mailbox hit.
    assign mbox_hit = ({wadr_q, 2'b00} == MAILBOX_ADDR);

    // The write commits at the end of RESP. Reset in that same cycle aborts it.
    assign ram_we = (state_q == ST_RESP) && write_q && !misal_q && !reset;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        done_d     = done_q;
        result_d   = result_q;
        misal_d    = misal_q;
        wadr_d     = wadr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;

        case (state_q)
            ST_IDLE: begin
                if (memreq) begin
                    wadr_d  = dataadr[31:2];
                    wdata_d = writedata;
                    write_d = memwrite;
                    misal_d = req_misal;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // memreq and the bus inputs are ignored here; the latched copy rules.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (write_q && !misal_q && mbox_hit) begin
                    done_d   = 1'b1;
                    result_d = wdata_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // readdata must be valid for the whole RESP cycle, so it is loaded on
        // the edge that enters RESP. The *_d request fields hold the fresh bus
        // values when coming straight from IDLE (WAIT_CYCLES == 0). Otherwise
        // they hold the latched values.
        if ((state_d == ST_RESP) && (state_q != ST_RESP) && !write_d) begin
            readdata_d = misal_d ? BAD_READ : ram[wadr_d[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            readdata_q <= 32'd0;
            done_q     <= 1'b0;
            result_q   <= 32'd0;
            misal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            done_q     <= done_d;
            result_q   <= result_d;
            misal_q    <= misal_d;
        end
    end

    always_ff @(posedge clk) begin
        wadr_q  <= wadr_d;
        wdata_q <= wdata_d;
        write_q <= write_d;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wadr_q[ADDR_W-1:0]] <= wdata_q;
        end
    end

    assign memready = (state_q == ST_RESP);
    assign readdata = readdata_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int W_MAIN = 2;

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq, memwrite;
    logic [31:0] dataadr, writedata;
    logic [31:0] readdata, result;
    logic        memready, done, misalign;

    logic        memreq_b, memwrite_b;
    logic [31:0] dataadr_b, writedata_b;
    logic [31:0] readdata_b, result_b;
    logic        memready_b, done_b, misalign_b;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(6), .WAIT_CYCLES(W_MAIN), .MAILBOX_ADDR(32'h54)) u_dut (
        .clk(clk), .reset(reset), .memreq(memreq), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .readdata(readdata),
        .memready(memready), .done(done), .result(result), .misalign(misalign)
    );

    data_mem_responder #(.ADDR_W(6), .WAIT_CYCLES(0), .MAILBOX_ADDR(32'h54)) u_dut_w0 (
        .clk(clk), .reset(reset), .memreq(memreq_b), .memwrite(memwrite_b),
        .dataadr(dataadr_b), .writedata(writedata_b), .readdata(readdata_b),
        .memready(memready_b), .done(done_b), .result(result_b), .misalign(misalign_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an array of words plus the mailbox and read registers.
    logic [31:0] ref_mem [64];
    bit          ref_known [64];
    bit          m_done;
    logic [31:0] m_result;
    logic [31:0] m_rd;
    bit          m_rd_known;

    task automatic model_reset();
        m_done     = 1'b0;
        m_result   = 32'd0;
        m_rd       = 32'd0;
        m_rd_known = 1'b1;
    endtask

    task automatic model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                               output bit exp_mis);
        int idx;
        idx     = int'((a / 4) % 64);
        exp_mis = ALIGN_ON && ((a % 4) != 0);
        if (w) begin
            if (!exp_mis) begin
                ref_mem[idx]   = d;
                ref_known[idx] = 1'b1;
                if ((a - (a % 4)) == 32'h54) begin
                    m_done   = 1'b1;
                    m_result = d;
                end
            end
        end else if (exp_mis) begin
            m_rd       = 32'hDEAD_BEEF;
            m_rd_known = 1'b1;
        end else begin
            m_rd       = ref_mem[idx];
            m_rd_known = ref_known[idx];
        end
    endtask

    // Runs one access on the main instance. It starts and ends at a negedge
    // while the DUT is idle and only observes; callers do the comparisons.
    task automatic bus_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic [31:0] rd,
                            output logic mis, output logic extra);
        memreq    = 1'b1;
        memwrite  = w;
        dataadr   = a;
        writedata = d;
        lat = -1;
        rd  = 32'd0;
        mis = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (memready) begin
                lat = k;
                rd  = readdata;
                mis = misalign;
                break;
            end
        end
        memreq   = 1'b0;
        memwrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        extra = memready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        memreq = 1'b0; memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
        memreq_b = 1'b0; memwrite_b = 1'b0; dataadr_b = 32'd0; writedata_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (memready !== 1'b0) begin n_fail++; $display("FAIL reset_memready: got %b expected 0", memready); end
        n_checks++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++;
        if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        n_checks++;
        if (memready_b !== 1'b0) begin n_fail++; $display("FAIL reset_memready_w0: got %b expected 0", memready_b); end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 64; i++) ref_known[i] = 1'b0;
    endtask

    task automatic test_rw();
        int lat; logic [31:0] rd; logic mis, extra; bit em;
        bus_xfer(1'b1, 32'h10, 32'h1234_5678, lat, rd, mis, extra);
        model_apply(1'b1, 32'h10, 32'h1234_5678, em);
        n_checks++;
        if (lat != W_MAIN + 1) begin n_fail++; $display("FAIL rw_write_latency: got %0d expected %0d", lat, W_MAIN + 1); end
        bus_xfer(1'b0, 32'h10, 32'd0, lat, rd, mis, extra);
        model_apply(1'b0, 32'h10, 32'd0, em);
        n_checks++;
        if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_readdata: got %h expected 12345678", rd); end
        n_checks++;
        if (extra !== 1'b0) begin n_fail++; $display("FAIL rw_single_pulse: got %b expected 0", extra); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rw_done: got %b expected 0", done); end
    endtask

    task automatic test_alias();
        int lat; logic [31:0] rd; logic mis, extra; bit em;
        bus_xfer(1'b1, 32'h110, 32'hA5, lat, rd, mis, extra);
        model_apply(1'b1, 32'h110, 32'hA5, em);
        bus_xfer(1'b0, 32'h010, 32'd0, lat, rd, mis, extra);
        model_apply(1'b0, 32'h010, 32'd0, em);
        n_checks++;
        if (rd !== 32'hA5) begin n_fail++; $display("FAIL alias_readdata: got %h expected 000000a5", rd); end
    endtask

    task automatic test_mailbox();
        int lat; logic [31:0] rd; logic mis, extra; bit em;
        bus_xfer(1'b1, 32'h54, 32'd7, lat, rd, mis, extra);
        model_apply(1'b1, 32'h54, 32'd7, em);
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL mbox_latency: got %0d expected 3", lat); end
        n_checks++;
        if (extra !== 1'b0) begin n_fail++; $display("FAIL mbox_single_pulse: got %b expected 0", extra); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL mbox_done: got %b expected 1", done); end
        n_checks++;
        if (result !== 32'd7) begin n_fail++; $display("FAIL mbox_result: got %h expected 7", result); end
        bus_xfer(1'b0, 32'h54, 32'd0, lat, rd, mis, extra);
        model_apply(1'b0, 32'h54, 32'd0, em);
        n_checks++;
        if (rd !== 32'd7) begin n_fail++; $display("FAIL mbox_readback: got %h expected 7", rd); end
        n_checks++;
        if (done !== 1'b1 || result !== 32'd7) begin
            n_fail++; $display("FAIL mbox_after_read: got done=%b result=%h expected done=1 result=7", done, result);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic mis, extra; bit em;
        memreq = 1'b1; memwrite = 1'b1; dataadr = 32'h54; writedata = 32'd9;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (memready !== 1'b0) begin n_fail++; $display("FAIL abort_wait_ready: got %b expected 0", memready); end
        reset = 1'b1;
        memreq = 1'b0; memwrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (done !== 1'b0 || result !== 32'd0) begin
            n_fail++; $display("FAIL abort_mailbox: got done=%b result=%h expected done=0 result=0", done, result);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (memready !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %b expected 0 (cycle %0d)", memready, i); end
            @(negedge clk);
        end
        bus_xfer(1'b0, 32'h54, 32'd0, lat, rd, mis, extra);
        model_apply(1'b0, 32'h54, 32'd0, em);
        n_checks++;
        if (rd === 32'd9 || rd !== m_rd) begin n_fail++; $display("FAIL abort_readback: got %h expected %h (not 9)", rd, m_rd); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done_after_read: got %b expected 0", done); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic mis, extra; bit em;
        bus_xfer(1'b1, 32'h56, 32'd5, lat, rd, mis, extra);
        model_apply(1'b1, 32'h56, 32'd5, em);
        n_checks++;
        if (mis !== em) begin n_fail++; $display("FAIL misal_write_flag: got %b expected %b", mis, em); end
        n_checks++;
        if (lat != W_MAIN + 1) begin n_fail++; $display("FAIL misal_latency: got %0d expected %0d", lat, W_MAIN + 1); end
        n_checks++;
        if (done !== m_done || result !== m_result) begin
            n_fail++; $display("FAIL misal_mailbox: got done=%b result=%h expected done=%b result=%h", done, result, m_done, m_result);
        end
        n_checks++;
        if (misalign !== 1'b0) begin n_fail++; $display("FAIL misal_flag_drops: got %b expected 0", misalign); end
        bus_xfer(1'b0, 32'h56, 32'd0, lat, rd, mis, extra);
        model_apply(1'b0, 32'h56, 32'd0, em);
        n_checks++;
        if (rd !== m_rd) begin n_fail++; $display("FAIL misal_readdata: got %h expected %h", rd, m_rd); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic mis, extra; bit em;
        logic [31:0] a, d, tmp;
        bit w;
        int r;
        for (int it = 0; it < 60; it++) begin
            tmp = $urandom();
            r   = $urandom_range(0, 7);
            if (r == 0)      a = 32'h54;
            else if (r == 1) a = (tmp & 32'hFFFF_FF00) | 32'h54;
            else             a = (tmp & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            w = 1'($urandom_range(0, 1));
            d = $urandom();
            bus_xfer(w, a, d, lat, rd, mis, extra);
            model_apply(w, a, d, em);
            n_checks++;
            if (lat != W_MAIN + 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, W_MAIN + 1); end
            n_checks++;
            if (extra !== 1'b0) begin n_fail++; $display("FAIL rand_single_pulse[%0d]: got %b expected 0", it, extra); end
            n_checks++;
            if (mis !== em) begin n_fail++; $display("FAIL rand_misalign[%0d]: got %b expected %b", it, mis, em); end
            if (m_rd_known) begin
                n_checks++;
                if (rd !== m_rd) begin n_fail++; $display("FAIL rand_readdata[%0d]: addr %h got %h expected %h", it, a, rd, m_rd); end
                n_checks++;
                if (readdata !== m_rd) begin n_fail++; $display("FAIL rand_readdata_hold[%0d]: got %h expected %h", it, readdata, m_rd); end
            end
            n_checks++;
            if (done !== m_done || result !== m_result) begin
                n_fail++; $display("FAIL rand_mailbox[%0d]: got done=%b result=%h expected done=%b result=%h", it, done, result, m_done, m_result);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          tw [6];
        logic [31:0] ta [6];
        logic [31:0] td [6];
        logic [31:0] b_mem [2];
        tw[0] = 1'b1; ta[0] = 32'h40; td[0] = 32'hCAFE_0001;
        tw[1] = 1'b1; ta[1] = 32'h44; td[1] = 32'h0BAD_0002;
        tw[2] = 1'b0; ta[2] = 32'h40; td[2] = 32'd0;
        tw[3] = 1'b0; ta[3] = 32'h44; td[3] = 32'd0;
        tw[4] = 1'b0; ta[4] = 32'h40; td[4] = 32'd0;
        tw[5] = 1'b0; ta[5] = 32'h44; td[5] = 32'd0;
        memreq_b = 1'b1;
        for (int t = 0; t < 6; t++) begin
            memwrite_b  = tw[t];
            dataadr_b   = ta[t];
            writedata_b = td[t];
            if (tw[t]) b_mem[(ta[t] - 32'h40) / 4] = td[t];
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (memready_b !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_high[%0d]: got %b expected 1", t, memready_b); end
            if (!tw[t]) begin
                n_checks++;
                if (readdata_b !== b_mem[(ta[t] - 32'h40) / 4]) begin
                    n_fail++; $display("FAIL b2b_readdata[%0d]: got %h expected %h", t, readdata_b, b_mem[(ta[t] - 32'h40) / 4]);
                end
            end
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (memready_b !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low[%0d]: got %b expected 0", t, memready_b); end
        end
        memreq_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_rw();
        test_alias();
        test_mailbox();
        test_reset_abort();
        test_misalign();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
